alu_seq: RTL and testbench

- Parametrised, sequential successor to the team's combinational ALU.
- Executes single-cycle arithmetic, logic, shift and compare ops, plus iterative multi-cycle MUL/DIVU/REMU.
- Operands enter on a valid/ready handshake; results leave on a second valid/ready handshake.
- Outputs are registered.
- Sits between the datapath issue stage and writeback; downstream may stall the result.

---
 rtl/alu_seq.sv | 195 +++++++++++++++++++
 tb/tb_alu_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle arith/logic/shift/compare plus iterative MUL/DIVU/REMU.
// Latency 1 cycle (single-cycle ops) or WIDTH+1 cycles (iterative); result held in HOLD until out_ready.
module alu_seq #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int CW = SHW + 1;
  localparam logic [3:0] OP_MUL  = 4'hA;
  localparam logic [3:0] OP_DIVU = 4'hB;
  localparam logic [3:0] OP_REMU = 4'hC;

  typedef enum logic [1:0] {IDLE, ITER, HOLD} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d, y_q, y_d;
  logic [3:0]       op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, ovf_q, ovf_d, zero_q, zero_d, neg_q, neg_d;

  logic [WIDTH:0]   add_s, sub_s, mul_s, div_sh;
  logic [WIDTH-1:0] div_df, sc_y, nxt_hi, nxt_lo, fin_y;
  logic             div_ge, sc_c, sc_v, fin_c, fin_v, is_iter;
  logic [SHW-1:0]   shamt;

  assign add_s   = {1'b0, a} + {1'b0, b};
  assign sub_s   = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
  assign shamt   = b[SHW-1:0];
  assign is_iter = (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);

  always_comb begin
    sc_y = '0;
    sc_c = 1'b0;
    sc_v = 1'b0;
    case (op)
      4'h0: begin
        sc_y = add_s[WIDTH-1:0];
        sc_c = add_s[WIDTH];
        sc_v = (a[WIDTH-1] == b[WIDTH-1]) && (add_s[WIDTH-1] != a[WIDTH-1]);
      end
      4'h1: begin
        sc_y = sub_s[WIDTH-1:0];
        sc_c = sub_s[WIDTH];
        sc_v = (a[WIDTH-1] != b[WIDTH-1]) && (sub_s[WIDTH-1] != a[WIDTH-1]);
      end
      4'h2: sc_y = a & b;
      4'h3: sc_y = a | b;
      4'h4: sc_y = a ^ b;
      4'h5: sc_y = a << shamt;
      4'h6: sc_y = a >> shamt;
      4'h7: sc_y = $signed(a) >>> shamt;
      4'h8: sc_y = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      4'h9: sc_y = {{(WIDTH-1){1'b0}}, a < b};
      default: sc_y = '0;
    endcase
  end

  // hi:lo is the product (MUL) or remainder:quotient (DIVU/REMU); lo starts as operand a.
  assign mul_s  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
  assign div_sh = {hi_q, lo_q[WIDTH-1]};
  assign div_ge = div_sh >= {1'b0, b_q};
  assign div_df = div_sh[WIDTH-1:0] - b_q;

  always_comb begin
    nxt_hi = hi_q;
    nxt_lo = lo_q;
    if (op_q == OP_MUL) begin
      nxt_hi = mul_s[WIDTH:1];
      nxt_lo = {mul_s[0], lo_q[WIDTH-1:1]};
    end else begin
      nxt_hi = div_ge ? div_df : div_sh[WIDTH-1:0];
      nxt_lo = {lo_q[WIDTH-2:0], div_ge};
    end
  end

  // A zero divisor falls out of the restoring loop as quotient=all ones, remainder=a.
  always_comb begin
    fin_y = nxt_lo;
    fin_c = 1'b0;
    fin_v = 1'b0;
    case (op_q)
      OP_MUL:  fin_c = |nxt_hi;
      OP_DIVU: fin_v = (b_q == '0);
      OP_REMU: begin
        fin_y = nxt_hi;
        fin_v = (b_q == '0);
      end
      default: fin_y = nxt_lo;
    endcase
  end

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    b_d     = b_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d = op;
          b_d  = b;
          if (is_iter) begin
            hi_d    = '0;
            lo_d    = a;
            cnt_d   = CW'(WIDTH);
            state_d = ITER;
          end else begin
            y_d     = sc_y;
            carry_d = sc_c;
            ovf_d   = sc_v;
            zero_d  = (sc_y == '0);
            neg_d   = sc_y[WIDTH-1];
            state_d = HOLD;
          end
        end
      end
      ITER: begin
        hi_d  = nxt_hi;
        lo_d  = nxt_lo;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          y_d     = fin_y;
          carry_d = fin_c;
          ovf_d   = fin_v;
          zero_d  = (fin_y == '0);
          neg_d   = fin_y[WIDTH-1];
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      b_q     <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      b_q     <= b_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == HOLD);
  assign y         = y_q;
  assign carry     = carry_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;
  assign negative  = neg_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=8: hand-computed vectors, latency, backpressure and abort.
module tb_alu_seq;
  logic       clk = 1'b0;
  logic       rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] a, b, y;
  logic [3:0] op;
  logic       carry, overflow, zero, negative;
  int         n_chk = 0;
  int         n_fail = 0;

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .carry(carry), .overflow(overflow), .zero(zero), .negative(negative)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one op, then waits (bounded) for out_valid with out_ready low; lat counts edges from accept.
  task automatic start_op(input logic [3:0] o, input logic [7:0] aa, input logic [7:0] bb, output int lat);
    in_valid = 1'b1; op = o; a = aa; b = bb; out_ready = 1'b0; lat = 0;
    do begin
      tick();
      lat++;
      in_valid = 1'b0; a = ~aa; b = ~bb; op = 4'h3;
    end while (!out_valid && lat < 40);
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; op = 4'h0; a = 8'h01; b = 8'h01; out_ready = 1'b0;
    repeat (3) begin
      tick();
      n_chk++; if ({out_valid, y, carry, overflow, zero, negative} !== 13'h0) begin
        n_fail++; $display("FAIL reset_outputs: got %h want 0", {out_valid, y, carry, overflow, zero, negative});
      end
    end
    in_valid = 1'b0; rst_n = 1'b1;
    tick();
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_chk++; if (out_valid !== 1'b0 || y !== 8'h00) begin
      n_fail++; $display("FAIL reset_no_result: got out_valid=%b y=%h want 0/00", out_valid, y);
    end
  endtask

  task automatic test_add_sub();
    int lat;
    start_op(4'h0, 8'h7F, 8'h01, lat);
    n_chk++; if (lat !== 1) begin n_fail++; $display("FAIL add_latency: got %0d want 1", lat); end
    n_chk++; if ({y, overflow, carry, negative} !== {8'h80, 1'b1, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL add_7f_01: got y=%h v=%b c=%b n=%b want 80 1 0 1", y, overflow, carry, negative);
    end
    release_result();
    start_op(4'h1, 8'h05, 8'h05, lat);
    n_chk++; if ({y, zero, carry, overflow} !== {8'h00, 1'b1, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL sub_5_5: got y=%h z=%b c=%b v=%b want 00 1 1 0", y, zero, carry, overflow);
    end
    release_result();
    start_op(4'h1, 8'h00, 8'h01, lat);
    n_chk++; if ({y, carry, overflow, negative} !== {8'hFF, 1'b0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL sub_0_1: got y=%h c=%b v=%b n=%b want ff 0 0 1", y, carry, overflow, negative);
    end
    release_result();
  endtask

  task automatic test_shift_cmp();
    logic [3:0] ops [6];
    logic [7:0] va  [6];
    logic [7:0] vb  [6];
    logic [7:0] vy  [6];
    int lat;
    ops[0] = 4'h7; va[0] = 8'h80; vb[0] = 8'h13; vy[0] = 8'hF0;
    ops[1] = 4'h8; va[1] = 8'hFF; vb[1] = 8'h01; vy[1] = 8'h01;
    ops[2] = 4'h9; va[2] = 8'hFF; vb[2] = 8'h01; vy[2] = 8'h00;
    ops[3] = 4'h5; va[3] = 8'h81; vb[3] = 8'hF9; vy[3] = 8'h02;
    ops[4] = 4'h6; va[4] = 8'h81; vb[4] = 8'h04; vy[4] = 8'h08;
    ops[5] = 4'h4; va[5] = 8'hF0; vb[5] = 8'h3C; vy[5] = 8'hCC;
    for (int i = 0; i < 6; i++) begin
      start_op(ops[i], va[i], vb[i], lat);
      n_chk++; if ({y, carry, overflow} !== {vy[i], 2'b00}) begin
        n_fail++; $display("FAIL shift_cmp[%0d] op=%h: got y=%h c=%b v=%b want %h 0 0", i, ops[i], y, carry, overflow, vy[i]);
      end
      release_result();
    end
  endtask

  task automatic test_mul_div();
    int lat;
    start_op(4'hA, 8'h10, 8'h11, lat);
    n_chk++; if (lat !== 9) begin n_fail++; $display("FAIL mul_latency: got %0d want 9", lat); end
    n_chk++; if ({y, carry, overflow} !== {8'h10, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL mul_10_11: got y=%h c=%b v=%b want 10 1 0", y, carry, overflow);
    end
    release_result();
    start_op(4'hA, 8'h0F, 8'h0F, lat);
    n_chk++; if ({y, carry} !== {8'hE1, 1'b0}) begin
      n_fail++; $display("FAIL mul_0f_0f: got y=%h c=%b want e1 0", y, carry);
    end
    release_result();
    start_op(4'hB, 8'd200, 8'd7, lat);
    n_chk++; if ({y, overflow} !== {8'd28, 1'b0} || lat !== 9) begin
      n_fail++; $display("FAIL divu_200_7: got y=%0d v=%b lat=%0d want 28 0 9", y, overflow, lat);
    end
    release_result();
    start_op(4'hC, 8'd200, 8'd7, lat);
    n_chk++; if ({y, overflow} !== {8'd4, 1'b0}) begin
      n_fail++; $display("FAIL remu_200_7: got y=%0d v=%b want 4 0", y, overflow);
    end
    release_result();
  endtask

  task automatic test_div_zero();
    int lat;
    start_op(4'hB, 8'h5A, 8'h00, lat);
    n_chk++; if ({y, overflow, carry} !== {8'hFF, 1'b1, 1'b0} || lat !== 9) begin
      n_fail++; $display("FAIL divu_by_zero: got y=%h v=%b c=%b lat=%0d want ff 1 0 9", y, overflow, carry, lat);
    end
    release_result();
    start_op(4'hC, 8'h5A, 8'h00, lat);
    n_chk++; if ({y, overflow, carry} !== {8'h5A, 1'b1, 1'b0} || lat !== 9) begin
      n_fail++; $display("FAIL remu_by_zero: got y=%h v=%b c=%b lat=%0d want 5a 1 0 9", y, overflow, carry, lat);
    end
    release_result();
  endtask

  task automatic test_backpressure();
    int lat;
    start_op(4'h0, 8'h03, 8'h04, lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; op = 4'h1; a = 8'h00; b = 8'h01;
      tick();
      n_chk++; if ({out_valid, in_ready, y, zero, carry, overflow} !== {1'b1, 1'b0, 8'h07, 3'b000}) begin
        n_fail++; $display("FAIL hold_stable[%0d]: got ov=%b ir=%b y=%h z=%b c=%b v=%b want 1 0 07 0 0 0",
                           i, out_valid, in_ready, y, zero, carry, overflow);
      end
    end
    in_valid = 1'b0;
    release_result();
    n_chk++; if ({out_valid, in_ready, y} !== {1'b0, 1'b1, 8'h07}) begin
      n_fail++; $display("FAIL hold_release: got ov=%b ir=%b y=%h want 0 1 07", out_valid, in_ready, y);
    end
  endtask

  task automatic test_abort();
    int lat;
    int seen = 0;
    in_valid = 1'b1; op = 4'hB; a = 8'd200; b = 8'd7; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    n_chk++; if ({out_valid, in_ready} !== 2'b00) begin
      n_fail++; $display("FAIL abort_in_iter: got ov=%b ir=%b want 0 0", out_valid, in_ready);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen++;
      tick();
    end
    n_chk++; if (seen !== 0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL abort_no_result: got valid_cycles=%0d ir=%b want 0 1", seen, in_ready);
    end
    start_op(4'hC, 8'd200, 8'd7, lat);
    n_chk++; if (y !== 8'd4 || lat !== 9) begin
      n_fail++; $display("FAIL abort_next_op: got y=%0d lat=%0d want 4 9", y, lat);
    end
    release_result();
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; op = 4'h0; a = 8'd10; b = 8'd20; out_ready = 1'b1;
    tick();
    n_chk++; if ({out_valid, in_ready, y} !== {1'b1, 1'b0, 8'd30}) begin
      n_fail++; $display("FAIL b2b_first: got ov=%b ir=%b y=%0d want 1 0 30", out_valid, in_ready, y);
    end
    a = 8'd1; b = 8'd1;
    tick();
    n_chk++; if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++; $display("FAIL b2b_gap: got ov=%b ir=%b want 0 1", out_valid, in_ready);
    end
    tick();
    n_chk++; if ({out_valid, in_ready, y} !== {1'b1, 1'b0, 8'd2}) begin
      n_fail++; $display("FAIL b2b_second: got ov=%b ir=%b y=%0d want 1 0 2", out_valid, in_ready, y);
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_shift_cmp();
    test_mul_div();
    test_div_zero();
    test_backpressure();
    test_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
